// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers (32 shift-add / restoring steps).
// Optional macro MULDIV_SIGNED_EN enables the signed mult/div path (op_i[0]=0).
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic        rd_req_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [5:0] LAST_C = 6'(ITER - 1);

  state_t      state_r, state_nx_s;
  logic [5:0]  cnt_r;
  logic        is_div_r;
  logic [31:0] b_r, q_r, acc_r;
  logic [31:0] hi_r, lo_r;
  logic        done_r;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] sum_s, shl_s;
  logic [31:0] acc_nx_s, q_nx_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, res_hi_s, res_lo_s;
  logic        start_ok_s, mt_ok_s, fin_s;

`ifdef MULDIV_SIGNED_EN
  logic neg_res_r, neg_rem_r;
  logic a_neg_s, b_neg_s;

  // Operand magnitudes and result signs for the signed path.
  always_comb begin
    a_neg_s = ~op_i[0] & opa_i[31];
    b_neg_s = ~op_i[0] & opb_i[31];
    a_mag_s = a_neg_s ? (32'd0 - opa_i) : opa_i;
    b_mag_s = b_neg_s ? (32'd0 - opb_i) : opb_i;
  end
`else
  logic unused_op_s;
  assign unused_op_s = op_i[0];
  assign a_mag_s = opa_i;
  assign b_mag_s = opb_i;
`endif

  // One shift-add (mult) or restoring-subtract (div) step; q_r holds multiplier or dividend/quotient.
  always_comb begin
    sum_s  = {1'b0, acc_r} + (q_r[0] ? {1'b0, b_r} : 33'd0);
    shl_s  = {acc_r, q_r[31]};
    if (is_div_r) begin
      if (shl_s >= {1'b0, b_r}) begin
        acc_nx_s = 32'(shl_s - {1'b0, b_r});
        q_nx_s   = {q_r[30:0], 1'b1};
      end else begin
        acc_nx_s = shl_s[31:0];
        q_nx_s   = {q_r[30:0], 1'b0};
      end
    end else begin
      acc_nx_s = sum_s[32:1];
      q_nx_s   = {sum_s[0], q_r[31:1]};
    end
  end

  // Final result of the last step, with sign correction when enabled.
  always_comb begin
    prod_s = {acc_nx_s, q_nx_s};
    quo_s  = q_nx_s;
    rem_s  = acc_nx_s;
`ifdef MULDIV_SIGNED_EN
    if (neg_res_r) begin
      prod_s = 64'd0 - prod_s;
      quo_s  = 32'd0 - quo_s;
    end else begin
      prod_s = prod_s;
    end
    if (neg_rem_r) begin
      rem_s = 32'd0 - rem_s;
    end else begin
      rem_s = rem_s;
    end
`endif
    if (is_div_r) begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // Next-state decode; DONE accepts a new issue exactly like IDLE.
  always_comb begin
    state_nx_s = state_r;
    start_ok_s = 1'b0;
    mt_ok_s    = 1'b0;
    fin_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        mt_ok_s = ~start_i;
        if (start_i && !flush_i) begin
          start_ok_s = 1'b1;
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_nx_s = IDLE;
        end else if (cnt_r == LAST_C) begin
          state_nx_s = DONE;
          fin_s      = 1'b1;
        end else begin
          state_nx_s = CALC;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      is_div_r <= 1'b0;
      b_r      <= 32'd0;
      q_r      <= 32'd0;
      acc_r    <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      done_r  <= fin_s;
      if (start_ok_s) begin
        is_div_r <= op_i[1];
        b_r      <= op_i[1] ? b_mag_s : a_mag_s;
        q_r      <= op_i[1] ? a_mag_s : b_mag_s;
        acc_r    <= 32'd0;
        cnt_r    <= 6'd0;
`ifdef MULDIV_SIGNED_EN
        neg_res_r <= a_neg_s ^ b_neg_s;
        neg_rem_r <= a_neg_s;
`endif
      end else if (state_r == CALC) begin
        acc_r <= acc_nx_s;
        q_r   <= q_nx_s;
        cnt_r <= cnt_r + 6'd1;
      end
      if (fin_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (mt_ok_s) begin
        if (mthi_i) hi_r <= wdata_i;
        if (mtlo_i) lo_r <= wdata_i;
      end
    end
  end

  assign busy_o  = (state_r == CALC);
  assign stall_o = busy_o & (start_i | rd_req_i | mthi_i | mtlo_i);
  assign done_o  = done_r;
  assign hi_o    = hi_r;
  assign lo_o    = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] opa_i = 32'd0;
  logic [31:0] opb_i = 32'd0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        rd_req_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_ctrl #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
    .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i), .rd_req_i(rd_req_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} for an operation, straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    longint sa, sb;
`ifdef MULDIV_SIGNED_EN
    sgn = ~op[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[1]) begin
      if (sgn) return 64'(sa * sb);
      return {32'd0, a} * {32'd0, b};
    end
    if (!sgn) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    if (b == 32'd0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk);
    mthi_i = 1'b1; wdata_i = hv;
    @(negedge clk);
    mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = lv;
    @(negedge clk);
    mtlo_i = 1'b0;
    m_hi = hv; m_lo = lv;
    check("mt_hi", {32'd0, hi_o}, {32'd0, m_hi});
    check("mt_lo", {32'd0, lo_o}, {32'd0, m_lo});
  endtask

  // Issue one op and check busy/stall/done/HI/LO every cycle; rd_at/flush_at of 0 mean unused.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int rd_at, input int flush_at);
    logic [63:0] exp;
    logic        exp_busy, exp_done, rd;
    logic [31:0] eh, el;
    exp = model(op, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      rd       = (rd_at != 0) && (c >= rd_at);
      rd_req_i = rd;
      flush_i  = (c == flush_at);
      #1;
      exp_busy = (c <= ((flush_at != 0) ? flush_at : 32));
      exp_done = (flush_at == 0) && (c == 33);
      eh = ((flush_at == 0) && (c >= 33)) ? exp[63:32] : m_hi;
      el = ((flush_at == 0) && (c >= 33)) ? exp[31:0] : m_lo;
      check({tag, "_busy"}, {63'd0, busy_o}, {63'd0, exp_busy});
      check({tag, "_done"}, {63'd0, done_o}, {63'd0, exp_done});
      check({tag, "_stall"}, {63'd0, stall_o}, {63'd0, exp_busy & rd});
      check({tag, "_hilo"}, {hi_o, lo_o}, {eh, el});
      @(negedge clk);
    end
    rd_req_i = 1'b0;
    flush_i  = 1'b0;
    if (flush_at == 0) begin
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    reset = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op("mult_rd", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0);

    mt_write(32'h0000_1234, 32'h0000_5678);
    run_op("mult_flush", 2'b00, 32'h0000_0003, 32'h0000_0005, 0, 10);

    // Reset in the middle of CALC clears HI/LO without waiting for a clock edge.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; opa_i = 32'd9; opb_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_rst", 2'b11, 32'd1000, 32'd7, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
